mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequencer and arbiter for a single-port unified memory shared by instruction fetch and data load/store in the RV32I core.
- Accepts req/ack transactions from the fetch stage and the data (load/store) stage.
- Picks one winner, drives the memory with word-aligned address, byte enables and lane-shifted write data, then waits for mem_ready.
- Returns fetch words raw, and load data lane-extracted and sign/zero-extended per funct3 (AddressingControl encoding).

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data and instruction width (fixed at 32 for RV32)
MAX_DATA_BURST, 4, consecutive data grants allowed while fetch waits before fetch is forced to win

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
if_req  input  1  fetch request, held until if_ack
if_addr  input  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
if_rdata  output  DATA_WIDTH  fetched instruction word, valid while if_ack
if_ack  output  1  one-cycle fetch completion pulse
d_req  input  1  data request, held until d_ack
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_WIDTH  data byte address
d_wdata  input  DATA_WIDTH  store data, right-aligned
d_addressing  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
d_rdata  output  DATA_WIDTH  extended load result, valid while d_ack
d_ack  output  1  one-cycle data completion pulse
mem_req  output  1  memory access active
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2],2'b00}
mem_wdata  output  DATA_WIDTH  lane-shifted store data
mem_be  output  4  byte enables
mem_rdata  input  DATA_WIDTH  memory read word
mem_ready  input  1  access complete this cycle

Behaviour:
- Reset: asynchronous. State goes to IDLE immediately (no clock needed). All outputs 0 and the starvation counter clears. A transaction in flight is abandoned and no ack is issued.
- FSM states: IDLE, IF_WAIT, D_WAIT, RESP. Request and address inputs are sampled only in IDLE.
- IDLE arbitration:
  - Only d_req set -> D_WAIT.
  - Only if_req set -> IF_WAIT.
  - Both set -> data wins, unless starve_cnt == MAX_DATA_BURST, in which case fetch wins.
  - Neither set -> stay in IDLE.
  - The winner's address, we, be and wdata are registered on the transition edge.
- IF_WAIT / D_WAIT:
  - mem_req=1 and memory outputs are held stable. mem_we is 0 in IF_WAIT.
  - When mem_ready=1: mem_rdata (processed for data) is captured and the FSM moves to RESP.
  - mem_ready is ignored outside the WAIT states.
- RESP: the selected ack is 1 for exactly one cycle with registered rdata, mem_req=0, then the FSM returns to IDLE.
- Latency: request seen in IDLE cycle 0 -> mem_req in cycle 1 -> with zero-wait memory, ack in cycle 2. Each wait cycle adds 1.
- A requester dropping req mid-transaction does not abort it; the ack is still pulsed.
- Starvation counter:
  - Increments on each data grant made while if_req=1, saturating at MAX_DATA_BURST.
  - Clears on any fetch grant, or on a data grant made while if_req=0.
- Store lanes, with o = d_addr[1:0]:
  - B: be = 0001<<o; wdata byte replicated to all lanes.
  - H: be = 0011<<{o[1],0}; halfword replicated.
  - W: be = 1111.
  - Loads drive be = 1111.
- Load extract: shift mem_rdata right by 8*o (H uses {o[1],0}). B/H sign-extend, BU/HU zero-extend, W passes through.
- Unused funct3 codes behave as W.
- Misalignment handling is defined under Optional Feature.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: adds output d_err (1 bit, reset 0). A data request that is H/HU with d_addr[0]=1, or W with d_addr[1:0]!=0, goes IDLE -> RESP directly with no memory access. In RESP, d_ack=1, d_err=1, d_rdata=0. d_err is 0 on every other ack. Misaligned requests still count as data grants for the starvation counter.
- Not defined: no d_err port. Misaligned low address bits are forced to alignment (H: bit0=0; W: bits[1:0]=0) and the access proceeds normally.

Test Plan:
- Fetch-only, zero-wait memory: if_req=1, if_addr=0x0000_0104, mem_rdata=0x0051_8193 -> mem_addr=0x104 in cycle 1, if_ack=1 with if_rdata=0x0051_8193 in cycle 2.
- Signed byte load with 2 wait cycles: d_addr=0x203, d_addressing=000, mem_rdata=0x80FF_0000 -> mem_req held 3 cycles, d_ack once, d_rdata=0xFFFF_FF80. Same access with 100 -> 0x0000_0080.
- Halfword store: d_we=1, d_addr=0x1002, d_addressing=001, d_wdata=0x1234_ABCD -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, mem_addr=0x1000.
- Starvation, MAX_DATA_BURST=4: d_req and if_req held high continuously -> grants D,D,D,D,IF,D..., counter back to 0 after the IF grant.
- Async reset asserted mid D_WAIT -> mem_req and all outputs 0 in the same cycle, no ack ever. After release, a pending if_req is served normally.
- Misaligned word load at 0x0000_0006:
  - With MISALIGN_TRAP_EN: no mem_req, d_ack and d_err in cycle 1, d_rdata=0.
  - Without: mem_addr=0x4, normal word load.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates a single-port unified memory between instruction fetch and
//   data load/store. It grants one requester, drives the word access, waits
//   for mem_ready, then pulses the matching ack for one cycle with the result.
//   Load results are lane-extracted and sign/zero-extended from funct3.
//
//   Optional macro MISALIGN_TRAP_EN:
//     defined     - adds d_err; a misaligned H/HU/W data access is completed
//                   immediately with d_err=1, d_rdata=0 and no memory access.
//     not defined - misaligned low address bits are dropped and the access
//                   proceeds on the aligned lanes.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   if_req/if_addr        fetch request, held until if_ack
//   if_rdata/if_ack       fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr     data request (store when d_we)
//   d_wdata/d_addressing  right-aligned store data, funct3 size/sign code
//   d_rdata/d_ack         extended load result, one-cycle completion pulse
//   d_err                 misalignment trap flag (MISALIGN_TRAP_EN only)
//   mem_*                 memory side: req/we/addr/wdata/be out, rdata/ready in
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [2:0]            d_addressing,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
`ifdef MISALIGN_TRAP_EN
    output logic                  d_err,
`endif
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int CW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DATA_BURST);

    typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  we_r;
    logic [3:0]            be_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [2:0]            f3_r;
    logic [1:0]            off_r;
    logic                  sel_d;
    logic                  err_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [CW-1:0]         starve_cnt;

    logic                  grant_d, grant_if, trap;
    logic                  is_b, is_h, is_w;
    logic [1:0]            d_off;
    logic [3:0]            d_be;
    logic [DATA_WIDTH-1:0] d_lane_wdata;
    logic [DATA_WIDTH-1:0] ld_shift, ld_data;
    logic                  unused_if_lsb;

    assign unused_if_lsb = ^if_addr[1:0];

    // Size decode; the unused funct3 codes fall through to word.
    assign is_b = (d_addressing == 3'b000) || (d_addressing == 3'b100);
    assign is_h = (d_addressing == 3'b001) || (d_addressing == 3'b101);
    assign is_w = !is_b && !is_h;

    // Lane offset rounded down to the access size, which also realigns
    // misaligned halfword/word accesses when they are not trapped.
    assign d_off = is_b ? d_addr[1:0] : is_h ? {d_addr[1], 1'b0} : 2'b00;

    always_comb begin
        d_be         = 4'b1111;
        d_lane_wdata = d_wdata;
        if (d_we && is_b) begin
            d_be         = 4'b0001 << d_off;
            d_lane_wdata = {4{d_wdata[7:0]}};
        end else if (d_we && is_h) begin
            d_be         = 4'b0011 << d_off;
            d_lane_wdata = {2{d_wdata[15:0]}};
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = (is_h && d_addr[0]) || (is_w && (d_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Load extraction uses the offset/funct3 captured at grant time.
    always_comb begin
        ld_shift = mem_rdata >> {off_r, 3'b000};
        case (f3_r)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_data = {24'd0, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Next state. Data wins ties unless fetch has been starved long enough.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(if_req && starve_cnt == MAX_CNT)) begin
                    grant_d   = 1'b1;
                    state_nxt = trap ? RESP : D_WAIT;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = IF_WAIT;
                end
            end
            IF_WAIT, D_WAIT: if (mem_ready) state_nxt = RESP;
            RESP:            state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r     <= '0;
            we_r       <= 1'b0;
            be_r       <= 4'b0000;
            wdata_r    <= '0;
            f3_r       <= 3'b000;
            off_r      <= 2'b00;
            sel_d      <= 1'b0;
            err_r      <= 1'b0;
            rdata_r    <= '0;
            starve_cnt <= '0;
        end else begin
            if (grant_if) begin
                addr_r     <= {if_addr[ADDR_WIDTH-1:2], 2'b00};
                we_r       <= 1'b0;
                be_r       <= 4'b1111;
                wdata_r    <= '0;
                f3_r       <= 3'b010;
                off_r      <= 2'b00;
                sel_d      <= 1'b0;
                err_r      <= 1'b0;
                starve_cnt <= '0;
            end
            if (grant_d) begin
                addr_r  <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
                we_r    <= d_we;
                be_r    <= d_be;
                wdata_r <= d_lane_wdata;
                f3_r    <= d_addressing;
                off_r   <= d_off;
                sel_d   <= 1'b1;
                err_r   <= trap;
                rdata_r <= '0;
                if (!if_req)                 starve_cnt <= '0;
                else if (starve_cnt != MAX_CNT) starve_cnt <= starve_cnt + 1'b1;
            end
            if (state == IF_WAIT && mem_ready) rdata_r <= mem_rdata;
            if (state == D_WAIT && mem_ready)  rdata_r <= ld_data;
        end
    end

    // Outputs decode from state so an async reset clears them at once.
    always_comb begin
        mem_req   = (state == IF_WAIT) || (state == D_WAIT);
        mem_we    = (state == D_WAIT) && we_r;
        mem_addr  = mem_req ? addr_r : '0;
        mem_be    = mem_req ? be_r : 4'b0000;
        mem_wdata = (state == D_WAIT) ? wdata_r : '0;
        if_ack    = (state == RESP) && !sel_d;
        d_ack     = (state == RESP) && sel_d;
        if_rdata  = if_ack ? rdata_r : '0;
        d_rdata   = d_ack ? rdata_r : '0;
`ifdef MISALIGN_TRAP_EN
        d_err     = d_ack && err_r;
`endif
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized
// single transactions checked against a byte-lane arithmetic model, a
// starvation sequence, and async reset in mid-access.
module tb_mem_port_arbiter;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_addressing;
    logic [31:0] d_rdata;
    logic        d_ack;
`ifdef MISALIGN_TRAP_EN
    logic        d_err;
`endif
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addressing(d_addressing), .d_rdata(d_rdata), .d_ack(d_ack),
`ifdef MISALIGN_TRAP_EN
        .d_err(d_err),
`endif
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request from IDLE and follow it through to the ack.
    // Requests are dropped and the request inputs scrambled after the grant
    // edge, so the access must run on registered values alone.
    task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] wd, input int waits,
                           input logic [31:0] rd, input logic [31:0] e_addr,
                           input logic [3:0] e_be, input logic [31:0] e_wd,
                           input logic [31:0] e_rd);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_addressing = f3; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        mem_rdata = rd;
        mem_ready = 1'b0;
        tick();
        if_req = 1'b0; d_req = 1'b0;
        d_addr = $urandom; d_wdata = $urandom; if_addr = $urandom; d_we = $urandom_range(0, 1);
        for (int w = 0; w <= waits; w++) begin
            check("mem_req", {31'd0, mem_req}, 32'd1);
            check("mem_we", {31'd0, mem_we}, {31'd0, is_d && we});
            check("mem_addr", mem_addr, e_addr);
            check("mem_be", {28'd0, mem_be}, {28'd0, e_be});
            if (is_d && we) check("mem_wdata", mem_wdata, e_wd);
            check("ack_early", {30'd0, if_ack, d_ack}, 32'd0);
            if (w == waits) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        check("ack", {30'd0, if_ack, d_ack}, is_d ? 32'd1 : 32'd2);
        check("mem_req_resp", {31'd0, mem_req}, 32'd0);
        if (!is_d)    check("if_rdata", if_rdata, e_rd);
        else if (!we) check("d_rdata", d_rdata, e_rd);
`ifdef MISALIGN_TRAP_EN
        check("d_err_clear", {31'd0, d_err}, 32'd0);
`endif
        tick();
        check("ack_single", {30'd0, if_ack, d_ack}, 32'd0);
    endtask

    initial begin
        int          sz, off, cnt, n;
        bit          is_d, we;
        logic [2:0]  f3;
        logic [2:0]  f3_tab [8];
        logic [31:0] addr, wd, rd, mask, v, e_wd, e_rd;
        logic [3:0]  e_be;

        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_addressing = 0; mem_rdata = 0; mem_ready = 0;
        #1;
        check("reset_outputs", {mem_req, mem_we, if_ack, d_ack, mem_be}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Directed cases.
        run_txn(0, 0, 32'h0000_0104, 3'b010, 0, 0, 32'h0051_8193, 32'h104, 4'hF, 0, 32'h0051_8193);
        run_txn(1, 0, 32'h0000_0203, 3'b000, 0, 2, 32'h80FF_0000, 32'h200, 4'hF, 0, 32'hFFFF_FF80);
        run_txn(1, 0, 32'h0000_0203, 3'b100, 0, 2, 32'h80FF_0000, 32'h200, 4'hF, 0, 32'h0000_0080);
        run_txn(1, 1, 32'h0000_1002, 3'b001, 32'h1234_ABCD, 0, 0, 32'h1000, 4'b1100, 32'hABCD_ABCD, 0);
        run_txn(1, 1, 32'h0000_0041, 3'b000, 32'h0000_005A, 1, 0, 32'h40, 4'b0010, 32'h5A5A_5A5A, 0);

`ifdef MISALIGN_TRAP_EN
        d_req = 1; d_we = 0; d_addr = 32'h6; d_addressing = 3'b010; mem_rdata = 32'hDEAD_BEEF;
        tick();
        d_req = 0;
        check("trap_no_mem", {31'd0, mem_req}, 32'd0);
        check("trap_ack", {31'd0, d_ack}, 32'd1);
        check("trap_err", {31'd0, d_err}, 32'd1);
        check("trap_rdata", d_rdata, 32'd0);
        tick();
        check("trap_ack_single", {31'd0, d_ack}, 32'd0);
`else
        run_txn(1, 0, 32'h0000_0006, 3'b010, 0, 0, 32'hDEAD_BEEF, 32'h4, 4'hF, 0, 32'hDEAD_BEEF);
`endif

        // Randomized single transactions against the byte-lane model.
        for (int t = 0; t < 40; t++) begin
            is_d = $urandom_range(0, 3) != 0;
            we   = is_d && ($urandom_range(0, 1) == 1);
            f3   = f3_tab[$urandom_range(0, 7)];
            addr = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            sz   = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
            if (is_d) addr = addr - (addr % sz);
`endif
            off  = int'(addr % 4) - int'(addr % 4) % sz;
            mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 1;
            if (!is_d) begin
                e_be = 4'hF; e_wd = 0; e_rd = rd;
            end else begin
                e_be = we ? 4'(((1 << sz) - 1) << off) : 4'hF;
                v    = wd & mask;
                e_wd = (sz == 1) ? v * 32'h0101_0101 : (sz == 2) ? v * 32'h0001_0001 : v;
                v    = (rd >> (8 * off)) & mask;
                if ((f3 == 3'b000 || f3 == 3'b001) && v >= (32'd1 << (8 * sz - 1)))
                    v = v - (32'd1 << (8 * sz));
                e_rd = v;
            end
            run_txn(is_d, we, addr, f3, wd, $urandom_range(0, 3), rd, addr & ~32'h3, e_be, e_wd, e_rd);
        end

        // Async reset in the middle of a data access.
        d_req = 1; d_we = 0; d_addr = 32'h300; d_addressing = 3'b010; mem_ready = 0;
        tick();
        d_req = 0;
        check("pre_reset_req", {31'd0, mem_req}, 32'd1);
        tick();
        if_req = 1; if_addr = 32'h0000_0800;
        #3 rst = 1'b1;
        #1;
        check("async_reset_req", {31'd0, mem_req}, 32'd0);
        check("async_reset_outs", {mem_we, if_ack, d_ack, mem_be}, 32'd0);
        check("async_reset_addr", mem_addr, 32'd0);
        mem_ready = 1;
        tick();
        check("reset_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
        mem_ready = 0;
        rst = 1'b0;
        run_txn(0, 0, 32'h0000_0802, 3'b010, 0, 1, 32'h1357_9BDF, 32'h800, 4'hF, 0, 32'h1357_9BDF);

        // Starvation: both requesters held high, memory always ready.
        cnt = 0;
        if_req = 1; if_addr = 32'h100;
        d_req = 1; d_we = 0; d_addr = 32'h200; d_addressing = 3'b010;
        mem_ready = 1;
        for (int g = 0; g < 10; g++) begin
            n = 0;
            while (!mem_req && n < 10) begin tick(); n++; end
            check("starve_grant_seen", {31'd0, n < 10}, 32'd1);
            check("starve_grant", mem_addr, (cnt == MAXB) ? 32'h100 : 32'h200);
            cnt = (cnt == MAXB) ? 0 : cnt + 1;
            tick();
        end
        if_req = 0; d_req = 0;
        tick(); tick(); tick();
        mem_ready = 0;
        check("quiet_end", {31'd0, mem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
